// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback request and register-file port bundle
//
// Purpose: groups the three writeback requesters (JAL link, load, ALU), the
// register-file write ports and the status outputs of regfile_wb_arbiter.
// Ports (slave = arbiter side):
//   link_valid/link_ready/link_data        JAL link-write request (r31)
//   load_valid/load_ready/load_addr/data   load writeback request
//   alu_valid/alu_ready/alu_addr/alu_data  ALU writeback request
//   rf_ena, rf_we/rf_waddr/rf_wdata        general register-file write port
//   rf_use_jal/rf_w_r31                    dedicated r31 link-write port
//   init_done, drop_cnt                    status
interface regfile_wb_arbiter_if;
    logic        link_valid;
    logic        link_ready;
    logic [31:0] link_data;

    logic        load_valid;
    logic        load_ready;
    logic [4:0]  load_addr;
    logic [31:0] load_data;

    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;

    logic        rf_ena;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_use_jal;
    logic [31:0] rf_w_r31;

    logic        init_done;
    logic [15:0] drop_cnt;

    modport slave (
        input  link_valid, link_data,
        input  load_valid, load_addr, load_data,
        input  alu_valid, alu_addr, alu_data,
        output link_ready, load_ready, alu_ready,
        output rf_ena, rf_we, rf_waddr, rf_wdata, rf_use_jal, rf_w_r31,
        output init_done, drop_cnt
    );

    modport master (
        output link_valid, link_data,
        output load_valid, load_addr, load_data,
        output alu_valid, alu_addr, alu_data,
        input  link_ready, load_ready, alu_ready,
        input  rf_ena, rf_we, rf_waddr, rf_wdata, rf_use_jal, rf_w_r31,
        input  init_done, drop_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file writeback arbiter with post-reset clear sweep
//
// Purpose: after reset, clears r1..r31 one per cycle, then arbitrates the
// JAL link, load and ALU writeback requesters onto the register-file ports.
// Priority is link > load > alu unless the ALU has waited STARVE_LIMIT
// cycles, in which case alu > link > load. Writes to r0 are accepted and
// counted in drop_cnt instead of being written.
// Ports:
//   clk    block clock, all state on posedge
//   rst_n  asynchronous active-low reset
//   bus    regfile_wb_arbiter_if.slave (requests, regfile ports, status)
module regfile_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    regfile_wb_arbiter_if.slave         bus
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  sweep_q, sweep_d;
    logic [3:0]  age_q, age_d;
    logic [15:0] drop_q, drop_d;
    logic        rf_ena_q;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        use_jal_q, use_jal_d;
    logic [31:0] w_r31_q, w_r31_d;

    logic        grant_link, grant_load, grant_alu;
    logic        starve;
    logic [4:0]  gpr_addr;
    logic [31:0] gpr_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            sweep_q   <= 5'd1;
            age_q     <= 4'd0;
            drop_q    <= 16'd0;
            rf_ena_q  <= 1'b0;
            rf_we_q   <= 1'b0;
            waddr_q   <= 5'd0;
            wdata_q   <= 32'd0;
            use_jal_q <= 1'b0;
            w_r31_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            age_q     <= age_d;
            drop_q    <= drop_d;
            rf_ena_q  <= 1'b1;
            rf_we_q   <= rf_we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            use_jal_q <= use_jal_d;
            w_r31_q   <= w_r31_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        age_d      = age_q;
        drop_d     = drop_q;
        rf_we_d    = 1'b0;
        use_jal_d  = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        w_r31_d    = w_r31_q;
        grant_link = 1'b0;
        grant_load = 1'b0;
        grant_alu  = 1'b0;
        starve     = (age_q >= STARVE_LIM);
        gpr_addr   = bus.load_addr;
        gpr_data   = bus.load_data;

        case (state_q)
            ST_INIT: begin
                // The sweep counter wraps 31 -> 0 after the last clear; seeing
                // 0 means r31 has been issued and the arbiter may start.
                if (sweep_q == 5'd0) begin
                    state_d = ST_RUN;
                end else begin
                    rf_we_d = 1'b1;
                    waddr_d = sweep_q;
                    wdata_d = 32'd0;
                    sweep_d = sweep_q + 5'd1;
                end
            end

            ST_RUN: begin
                if (starve && bus.alu_valid) begin
                    grant_alu = 1'b1;
                end else if (bus.link_valid) begin
                    grant_link = 1'b1;
                end else if (bus.load_valid) begin
                    grant_load = 1'b1;
                end else if (bus.alu_valid) begin
                    grant_alu = 1'b1;
                end

                // Age saturates so a very long wait cannot wrap back below
                // the starvation threshold.
                if (!bus.alu_valid || grant_alu) begin
                    age_d = 4'd0;
                end else if (age_q != 4'hF) begin
                    age_d = age_q + 4'd1;
                end

                if (grant_alu) begin
                    gpr_addr = bus.alu_addr;
                    gpr_data = bus.alu_data;
                end

                if (grant_link) begin
                    use_jal_d = 1'b1;
                    w_r31_d   = bus.link_data;
                end else if (grant_load || grant_alu) begin
                    if (gpr_addr != 5'd0) begin
                        rf_we_d = 1'b1;
                        waddr_d = gpr_addr;
                        wdata_d = gpr_data;
                    end else if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                end
            end

            default: state_d = ST_INIT;
        endcase
    end

    // A grant always implies the matching valid, so ready doubles as the
    // transfer strobe.
    assign bus.link_ready = grant_link;
    assign bus.load_ready = grant_load;
    assign bus.alu_ready  = grant_alu;

    assign bus.rf_ena     = rf_ena_q;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_waddr   = waddr_q;
    assign bus.rf_wdata   = wdata_q;
    assign bus.rf_use_jal = use_jal_q;
    assign bus.rf_w_r31   = w_r31_q;
    assign bus.init_done  = (state_q == ST_RUN);
    assign bus.drop_cnt   = drop_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ready(input string tag, input logic lk, input logic ld, input logic al);
        chk({tag, ".link_ready"}, 32'(bus.link_ready), 32'(lk));
        chk({tag, ".load_ready"}, 32'(bus.load_ready), 32'(ld));
        chk({tag, ".alu_ready"},  32'(bus.alu_ready),  32'(al));
    endtask

    task automatic sweep_check(input string tag);
        for (int k = 1; k <= 31; k++) begin
            step();
            chk($sformatf("%s.we%0d", tag, k),    32'(bus.rf_we), 32'd1);
            chk($sformatf("%s.waddr%0d", tag, k), 32'(bus.rf_waddr), 32'(k));
            chk($sformatf("%s.wdata%0d", tag, k), bus.rf_wdata, 32'd0);
            chk($sformatf("%s.idone%0d", tag, k), 32'(bus.init_done), 32'd0);
            chk($sformatf("%s.ena%0d", tag, k),   32'(bus.rf_ena), 32'd1);
            chk_ready($sformatf("%s.rdy%0d", tag, k), 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        bus.link_valid = 1'b0; bus.link_data = 32'd0;
        bus.load_valid = 1'b0; bus.load_addr = 5'd0; bus.load_data = 32'd0;
        bus.alu_valid  = 1'b0; bus.alu_addr  = 5'd0; bus.alu_data  = 32'd0;

        // Reset state
        #2;
        chk("rst.ena",   32'(bus.rf_ena), 32'd0);
        chk("rst.we",    32'(bus.rf_we), 32'd0);
        chk("rst.jal",   32'(bus.rf_use_jal), 32'd0);
        chk("rst.idone", 32'(bus.init_done), 32'd0);
        chk("rst.drop",  32'(bus.drop_cnt), 32'd0);
        chk("rst.waddr", 32'(bus.rf_waddr), 32'd0);
        chk("rst.r31",   bus.rf_w_r31, 32'd0);
        #20;
        rst_n = 1'b1;
        #1;
        chk("rel.ena", 32'(bus.rf_ena), 32'd0);

        // Clear sweep r1..r31, then RUN
        sweep_check("sweep");
        step();
        chk("run.idone", 32'(bus.init_done), 32'd1);
        chk("run.we",    32'(bus.rf_we), 32'd0);

        // Three simultaneous requests: link, then load, then alu
        bus.link_valid = 1'b1; bus.link_data = 32'h0000_1004;
        bus.load_valid = 1'b1; bus.load_addr = 5'd5; bus.load_data = 32'h5555_0005;
        bus.alu_valid  = 1'b1; bus.alu_addr  = 5'd6; bus.alu_data  = 32'h6666_0006;
        #1;
        chk_ready("tri1", 1'b1, 1'b0, 1'b0);
        step();
        bus.link_valid = 1'b0;
        #1;
        chk("tri2.jal",   32'(bus.rf_use_jal), 32'd1);
        chk("tri2.r31",   bus.rf_w_r31, 32'h0000_1004);
        chk("tri2.we",    32'(bus.rf_we), 32'd0);
        chk_ready("tri2", 1'b0, 1'b1, 1'b0);
        step();
        bus.load_valid = 1'b0;
        #1;
        chk("tri3.jal",   32'(bus.rf_use_jal), 32'd0);
        chk("tri3.we",    32'(bus.rf_we), 32'd1);
        chk("tri3.waddr", 32'(bus.rf_waddr), 32'd5);
        chk("tri3.wdata", bus.rf_wdata, 32'h5555_0005);
        chk_ready("tri3", 1'b0, 1'b0, 1'b1);
        step();
        bus.alu_valid = 1'b0;
        #1;
        chk("tri4.we",    32'(bus.rf_we), 32'd1);
        chk("tri4.waddr", 32'(bus.rf_waddr), 32'd6);
        chk("tri4.wdata", bus.rf_wdata, 32'h6666_0006);
        step();
        chk("idle.we",    32'(bus.rf_we), 32'd0);
        chk("idle.jal",   32'(bus.rf_use_jal), 32'd0);
        chk("idle.waddr", 32'(bus.rf_waddr), 32'd6);
        chk("idle.r31",   bus.rf_w_r31, 32'h0000_1004);

        // Starvation: load held high, alu waits 4 cycles then wins on the 5th
        bus.load_valid = 1'b1; bus.load_addr = 5'd7; bus.load_data = 32'h7777_0007;
        bus.alu_valid  = 1'b1; bus.alu_addr  = 5'd9; bus.alu_data  = 32'h9999_0009;
        #1;
        for (int c = 1; c <= 5; c++) begin
            chk_ready($sformatf("stv%0d", c), 1'b0, (c != 5), (c == 5));
            if (c > 1) chk($sformatf("stv%0d.waddr", c), 32'(bus.rf_waddr), 32'd7);
            step();
        end
        bus.alu_valid = 1'b0;
        #1;
        chk("stv6.we",    32'(bus.rf_we), 32'd1);
        chk("stv6.waddr", 32'(bus.rf_waddr), 32'd9);
        chk("stv6.wdata", bus.rf_wdata, 32'h9999_0009);
        chk_ready("stv6", 1'b0, 1'b1, 1'b0);
        step();
        bus.load_valid = 1'b0;
        chk("stv7.waddr", 32'(bus.rf_waddr), 32'd7);
        #1;
        step();

        // Writes to r0 are accepted but dropped and counted
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd0; bus.alu_data = 32'hDEAD_BEEF;
        #1;
        chk_ready("r0a", 1'b0, 1'b0, 1'b1);
        step();
        bus.alu_valid = 1'b0;
        #1;
        chk("r0a.we",    32'(bus.rf_we), 32'd0);
        chk("r0a.drop",  32'(bus.drop_cnt), 32'd1);
        chk("r0a.wdata", bus.rf_wdata, 32'h7777_0007);
        bus.load_valid = 1'b1; bus.load_addr = 5'd0; bus.load_data = 32'h1234_5678;
        #1;
        chk_ready("r0b", 1'b0, 1'b1, 1'b0);
        step();
        bus.load_valid = 1'b0;
        #1;
        chk("r0b.we",   32'(bus.rf_we), 32'd0);
        chk("r0b.drop", 32'(bus.drop_cnt), 32'd2);

        // Reset while a load write sits in the output stage
        bus.load_valid = 1'b1; bus.load_addr = 5'd12; bus.load_data = 32'hC0DE_000C;
        step();
        bus.load_valid = 1'b0;
        #1;
        chk("mid.we",    32'(bus.rf_we), 32'd1);
        chk("mid.waddr", 32'(bus.rf_waddr), 32'd12);
        rst_n = 1'b0;
        #1;
        chk("mid.rst_we",    32'(bus.rf_we), 32'd0);
        chk("mid.rst_drop",  32'(bus.drop_cnt), 32'd0);
        chk("mid.rst_waddr", 32'(bus.rf_waddr), 32'd0);
        chk("mid.rst_ena",   32'(bus.rf_ena), 32'd0);
        chk("mid.rst_idone", 32'(bus.init_done), 32'd0);

        // Requests held through reset and the whole sweep
        bus.link_valid = 1'b1; bus.link_data = 32'h0040_1234;
        bus.load_valid = 1'b1; bus.load_addr = 5'd3; bus.load_data = 32'h3333_0003;
        bus.alu_valid  = 1'b1; bus.alu_addr  = 5'd4; bus.alu_data  = 32'h4444_0004;
        #1;
        chk_ready("inrst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_ready("rel2", 1'b0, 1'b0, 1'b0);
        sweep_check("sweep2");
        step();
        chk("run2.idone", 32'(bus.init_done), 32'd1);
        chk_ready("run2", 1'b1, 1'b0, 1'b0);
        step();
        bus.link_valid = 1'b0;
        #1;
        chk("run3.jal", 32'(bus.rf_use_jal), 32'd1);
        chk("run3.r31", bus.rf_w_r31, 32'h0040_1234);
        chk_ready("run3", 1'b0, 1'b1, 1'b0);
        step();
        bus.load_valid = 1'b0;
        #1;
        chk("run4.waddr", 32'(bus.rf_waddr), 32'd3);
        chk("run4.wdata", bus.rf_wdata, 32'h3333_0003);
        chk_ready("run4", 1'b0, 1'b0, 1'b1);
        step();
        bus.alu_valid = 1'b0;
        #1;
        chk("run5.waddr", 32'(bus.rf_waddr), 32'd4);
        chk("run5.wdata", bus.rf_wdata, 32'h4444_0004);
        chk("run5.drop",  32'(bus.drop_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
